// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared types and constants for the modular-exponentiation sequencer.
package mont_pkg;

    localparam int DEFAULT_WIDTH     = 1024;
    localparam int DEFAULT_EXP_WIDTH = 1024;

    localparam logic [DEFAULT_WIDTH-1:0] MONT_ONE = DEFAULT_WIDTH'(1);

    // SKIP is only reachable when leading-zero skipping is compiled in.
    typedef enum logic [3:0] {
        IDLE,
        PRE,
        PRE_W,
        SQ,
        SQ_W,
        MUL,
        MUL_W,
        POST,
        POST_W,
        DONE,
        SKIP
    } state_t;

endpackage

// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Optional MONTEXP_SKIP_LEADING_ZEROS_EN: skip squarings before the first set exponent bit (public exponents only).
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done
);

    localparam int CW = $clog2(EXP_WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(MONT_ONE);

    state_t               state_q;
    logic [WIDTH-1:0]     a_q, xt_q, x_q, r2_q, m_q, result_q, mm_a_q, mm_b_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic [CW-1:0]        cnt_q;
    logic                 done_q, busy_q, mm_start_q;

    logic                 mm_ack;
    logic                 last_bit;

    // The multiplier cannot finish in the cycle it is started, so a done seen then is stray.
    assign mm_ack   = mm_done && !mm_start_q;
    assign last_bit = (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            xt_q       <= '0;
            x_q        <= '0;
            r2_q       <= '0;
            m_q        <= '0;
            e_q        <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            mm_start_q <= 1'b0;
        end else begin
            mm_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= in_x;
                        m_q     <= in_m;
                        r2_q    <= in_r2;
                        a_q     <= in_r;
                        e_q     <= in_e;
                        cnt_q   <= CW'(EXP_WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= PRE;
                    end
                end
                PRE: begin
                    mm_start_q <= 1'b1;
                    mm_a_q     <= x_q;
                    mm_b_q     <= r2_q;
                    state_q    <= PRE_W;
                end
                PRE_W: begin
                    if (mm_ack) begin
                        xt_q <= mm_result;
`ifdef MONTEXP_SKIP_LEADING_ZEROS_EN
                        if (e_q == '0)
                            state_q <= POST;
                        else if (e_q[EXP_WIDTH-1])
                            state_q <= SQ;
                        else
                            state_q <= SKIP;
`else
                        state_q <= (cnt_q == '0) ? POST : SQ;
`endif
                    end
                end
`ifdef MONTEXP_SKIP_LEADING_ZEROS_EN
                SKIP: begin
                    // e is non-zero here, so the set bit arrives before cnt runs out.
                    e_q   <= e_q << 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (e_q[EXP_WIDTH-2])
                        state_q <= SQ;
                end
`endif
                SQ: begin
                    mm_start_q <= 1'b1;
                    mm_a_q     <= a_q;
                    mm_b_q     <= a_q;
                    state_q    <= SQ_W;
                end
                SQ_W: begin
                    if (mm_ack) begin
                        a_q <= mm_result;
                        if (e_q[EXP_WIDTH-1]) begin
                            state_q <= MUL;
                        end else begin
                            e_q     <= e_q << 1;
                            cnt_q   <= cnt_q - CW'(1);
                            state_q <= last_bit ? POST : SQ;
                        end
                    end
                end
                MUL: begin
                    mm_start_q <= 1'b1;
                    mm_a_q     <= a_q;
                    mm_b_q     <= xt_q;
                    state_q    <= MUL_W;
                end
                MUL_W: begin
                    if (mm_ack) begin
                        a_q     <= mm_result;
                        e_q     <= e_q << 1;
                        cnt_q   <= cnt_q - CW'(1);
                        state_q <= last_bit ? POST : SQ;
                    end
                end
                POST: begin
                    mm_start_q <= 1'b1;
                    mm_a_q     <= a_q;
                    mm_b_q     <= ONE;
                    state_q    <= POST_W;
                end
                POST_W: begin
                    if (mm_ack) begin
                        result_q <= mm_result;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb/tb_mont_exp_ctrl.sv - randomized self-checking bench for mont_exp_ctrl with a behavioural multiplier responder.
module tb_mont_exp_ctrl;

    localparam int W  = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [W-1:0]  in_x, in_m, in_r, in_r2, result, mm_a, mm_b, mm_m, mm_result;
    logic [EW-1:0] in_e;
    logic          done, busy, mm_start, mm_done;

    int errors = 0;
    int checks = 0;

    int max_delay = 1;
    bit rand_delay = 1'b0;
    bit spur_en = 1'b0;
    bit pend = 1'b0;
    int rcnt;
    logic [W-1:0] ra, rb, rm;
    int n_starts = 0, n_overlap = 0, n_unstable = 0, n_done = 0;

    mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    // Montgomery product a*b*R^-1 mod m, R = 2^W, by brute-force inverse.
    function automatic longint mont(longint a, longint b, longint m);
        longint rinv = 0;
        for (longint k = 1; k < m; k++)
            if (((longint'(1) << W) * k) % m == 1) rinv = k;
        return ((a * b) % m) * rinv % m;
    endfunction

    function automatic longint pow_mod(longint x, int e, longint m);
        longint r = 1 % m;
        for (int i = 0; i < e; i++) r = (r * x) % m;
        return r;
    endfunction

    function automatic int popc(int e);
        int p = 0;
        for (int i = 0; i < EW; i++) if (((e >> i) & 1) == 1) p++;
        return p;
    endfunction

    function automatic int hbit(int e);
        int h = -1;
        for (int i = 0; i < EW; i++) if (((e >> i) & 1) == 1) h = i;
        return h;
    endfunction

    function automatic int exp_mults(int e);
`ifdef MONTEXP_SKIP_LEADING_ZEROS_EN
        if (e == 0) return 2;
        return 2 + hbit(e) + 1 + popc(e);
`else
        return 2 + EW + popc(e);
`endif
    endfunction

    function automatic int exp_skip(int e);
`ifdef MONTEXP_SKIP_LEADING_ZEROS_EN
        if (e == 0) return 0;
        return EW - 1 - hbit(e);
`else
        return 0 * e;
`endif
    endfunction

    // Responder: latency is (delay + 1) cycles from the mm_start cycle to the mm_done cycle.
    always @(posedge clk) begin
        mm_done <= 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else if (pend) begin
            if (mm_a !== ra || mm_b !== rb || mm_m !== rm) n_unstable++;
            if (mm_start === 1'b1) n_overlap++;
            if (rcnt <= 1) begin
                mm_done   <= 1'b1;
                mm_result <= W'(mont(longint'(ra), longint'(rb), longint'(rm)));
                pend = 1'b0;
            end else begin
                rcnt--;
            end
        end else if (mm_start === 1'b1) begin
            n_starts++;
            pend = 1'b1;
            ra = mm_a;
            rb = mm_b;
            rm = mm_m;
            rcnt = rand_delay ? int'($urandom_range(1, max_delay)) : max_delay;
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
            mm_done   <= 1'b1;
            mm_result <= W'($urandom);
        end
    end

    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic run_op(input int x, input int e, input int m,
                          output logic [W-1:0] res, output int cyc, output bit ok);
        in_x  = W'(x);
        in_e  = EW'(e);
        in_m  = W'(m);
        in_r  = W'((1 << W) % m);
        in_r2 = W'((1 << (2 * W)) % m);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        ok  = (done === 1'b1);
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        in_x = '0; in_e = '0; in_m = 8'hF1; in_r = '0; in_r2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, busy, mm_start, result, mm_a, mm_b, mm_m} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {done, busy, mm_start, result, mm_a, mm_b, mm_m});
        end
    endtask

    task automatic test_vectors();
        int tx[4] = '{3, 'h37, 'hF0, 'h10};
        int te[4] = '{5, 0, 2, 1};
        int tr[4] = '{2, 1, 1, 'h10};
        logic [W-1:0] res;
        int cyc, exp_cyc;
        bit ok;
        rand_delay = 1'b0;
        max_delay  = 3;
        spur_en    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_starts = 0;
            n_done   = 0;
            run_op(tx[i], te[i], 'hF1, res, cyc, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL vec%0d_timeout: done not seen after %0d cycles", i, cyc);
            end
            checks++;
            if (res !== W'(tr[i])) begin
                errors++;
                $display("FAIL vec%0d_result: got %h required %h", i, res, tr[i]);
            end
            checks++;
            if (n_starts != exp_mults(te[i])) begin
                errors++;
                $display("FAIL vec%0d_mm_starts: got %0d required %0d", i, n_starts, exp_mults(te[i]));
            end
            exp_cyc = exp_mults(te[i]) * (max_delay + 1 + 2) + 2 + exp_skip(te[i]);
            checks++;
            if (cyc != exp_cyc) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d required %0d", i, cyc, exp_cyc);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (n_done != 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_done_once: done pulses %0d busy %b required 1 and 0", i, n_done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] res;
        int cyc, m, x, e;
        bit ok;
        rand_delay = 1'b1;
        max_delay  = 20;
        spur_en    = 1'b1;
        n_unstable = 0;
        n_overlap  = 0;
        for (int i = 0; i < 12; i++) begin
            m = int'($urandom_range(1, 127)) * 2 + 1;
            x = int'($urandom_range(0, m - 1));
            e = int'($urandom_range(0, 255));
            n_starts = 0;
            run_op(x, e, m, res, cyc, ok);
            checks++;
            if (!ok || res !== W'(pow_mod(x, e, m))) begin
                errors++;
                $display("FAIL rand%0d_result: x=%0d e=%0d m=%0d got %h required %h (done=%b)",
                         i, x, e, m, res, W'(pow_mod(x, e, m)), ok);
            end
            checks++;
            if (n_starts != exp_mults(e)) begin
                errors++;
                $display("FAIL rand%0d_mm_starts: got %0d required %0d", i, n_starts, exp_mults(e));
            end
        end
        spur_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (n_unstable != 0 || n_overlap != 0) begin
            errors++;
            $display("FAIL operand_stability: unstable %0d overlap %0d required 0 and 0", n_unstable, n_overlap);
        end
    endtask

    task automatic test_busy_start();
        int cyc, starts_at_done;
        rand_delay = 1'b0;
        max_delay  = 2;
        n_starts = 0;
        n_done   = 0;
        in_x = 8'h03; in_e = 8'd5; in_m = 8'hF1; in_r = 8'h0F; in_r2 = 8'hE1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        in_x = 8'h10; in_e = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || result !== 8'h02) begin
            errors++;
            $display("FAIL busy_restart_result: got %h done %b required 02 and 1", result, done);
        end
        starts_at_done = n_starts;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_starts != starts_at_done) begin
            errors++;
            $display("FAIL start_in_done_cycle: busy %b new mm_starts %0d required 0 and 0",
                     busy, n_starts - starts_at_done);
        end
        checks++;
        if (n_done != 1 || starts_at_done != exp_mults(5)) begin
            errors++;
            $display("FAIL busy_restart_counts: done %0d mm_starts %0d required 1 and %0d",
                     n_done, starts_at_done, exp_mults(5));
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] res;
        int cyc;
        bit ok;
        rand_delay = 1'b0;
        max_delay  = 2;
        in_x = 8'h03; in_e = 8'hFF; in_m = 8'hF1; in_r = 8'h0F; in_r2 = 8'hE1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        n_done = 0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({done, busy, mm_start, result, mm_a, mm_b, mm_m} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h required 0", {done, busy, mm_start, result, mm_a, mm_b, mm_m});
        end
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (n_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_done: done pulses %0d busy %b required 0 and 0", n_done, busy);
        end
        run_op('h10, 1, 'hF1, res, cyc, ok);
        checks++;
        if (!ok || res !== 8'h10) begin
            errors++;
            $display("FAIL after_reset_result: got %h done %b required 10 and 1", res, ok);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_busy_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
